neuron_integrator: RTL and testbench

Downstream stage of the synaptic charger. On each timestep it scans all N neurons four at a time. For each neuron it reads the accumulated signed 8-bit charge from the charger, integrates it into a per-neuron membrane potential with leak and saturation, and compares the result against a threshold. Spiking neurons are emitted one address per valid/ready handshake. At the end of the pass it pulses a clear request back to the charger.

---
 rtl/neuron_integrator.sv | 190 +++++++++++++++++++
 tb/tb_neuron_integrator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_integrator.sv
// neuron_integrator
// Scans N membrane potentials four per cycle. Each neuron integrates its
// charge from the synaptic charger, subtracts a leak and saturates to 8 bits.
// A neuron whose result reaches the threshold resets to 0 and is emitted as
// one spike address per valid/ready handshake. Each pass ends with a
// done/charge-clear pulse.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             begin a pass (IDLE only)
//   threshold_i         signed firing threshold, latched on start
//   leak_i              unsigned leak per pass, latched on start
//   charge_count_o      group index g presented to the charger
//   synapse_charge_i    four signed charges for group g (byte k = neuron 4g+k)
//   spike_valid_o/spike_ready_i/spike_addr_o   spike address stream
//   busy_o              not IDLE
//   done_o              one-cycle end-of-pass pulse
//   charge_clear_o      one-cycle pulse with done_o, charger zeroes charges
module neuron_integrator #(
  parameter int N = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [7:0]                threshold_i,
  input  logic [3:0]                leak_i,
  output logic [$clog2(N/4)-1:0]    charge_count_o,
  input  logic [31:0]               synapse_charge_i,
  output logic                      spike_valid_o,
  input  logic                      spike_ready_i,
  output logic [$clog2(N)-1:0]      spike_addr_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      charge_clear_o
);

  localparam int GW = $clog2(N/4);
  localparam int AW = $clog2(N);
  localparam logic [GW-1:0] G_LAST = GW'(N/4 - 1);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t                   state_q;
  logic [GW-1:0]            g_q;
  logic signed [7:0]        thr_q;
  logic [3:0]               lk_q;
  logic [3:0]               pend_q;
  logic signed [7:0]        vmem_q [N];
  logic                     spike_valid_q;
  logic [AW-1:0]            spike_addr_q;
  logic                     busy_q;
  logic                     done_q;

  logic signed [7:0]        cur_d  [4];
  logic signed [7:0]        chg_d  [4];
  logic signed [9:0]        sum_d  [4];
  logic signed [7:0]        vnew_d [4];
  logic [3:0]               fire_d;
  logic [3:0]               pend_rest_d;

  function automatic logic signed [7:0] sat8(input logic signed [9:0] s);
    if (s > 10'sd127) begin
      return 8'sd127;
    end else if (s < -10'sd128) begin
      return -8'sd128;
    end else begin
      return s[7:0];
    end
  endfunction

  function automatic logic [1:0] lsb_idx(input logic [3:0] m);
    if (m[0]) begin
      return 2'd0;
    end else if (m[1]) begin
      return 2'd1;
    end else if (m[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  // Integrate/leak/saturate/threshold for the four neurons of group g.
  // Sums are formed at 10 bits so vmem + charge - leak cannot wrap before
  // saturation.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cur_d[k]  = '0;
      chg_d[k]  = '0;
      sum_d[k]  = '0;
      vnew_d[k] = '0;
    end
    fire_d = '0;
    for (int k = 0; k < 4; k++) begin
      cur_d[k]  = vmem_q[{g_q, 2'(k)}];
      chg_d[k]  = synapse_charge_i[8*k +: 8];
      sum_d[k]  = {{2{cur_d[k][7]}}, cur_d[k]}
                + {{2{chg_d[k][7]}}, chg_d[k]}
                - {6'd0, lk_q};
      vnew_d[k] = sat8(sum_d[k]);
      fire_d[k] = (vnew_d[k] >= thr_q);
    end
    // Pending mask with its lowest set bit (the spike being accepted) removed.
    pend_rest_d = pend_q & (pend_q - 4'd1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      g_q           <= '0;
      thr_q         <= '0;
      lk_q          <= '0;
      pend_q        <= '0;
      spike_valid_q <= 1'b0;
      spike_addr_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      for (int i = 0; i < N; i++) begin
        vmem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            thr_q   <= threshold_i;
            lk_q    <= leak_i;
            g_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end

        SCAN: begin
          for (int k = 0; k < 4; k++) begin
            vmem_q[{g_q, 2'(k)}] <= fire_d[k] ? 8'sd0 : vnew_d[k];
          end
          if (|fire_d) begin
            pend_q        <= fire_d;
            spike_valid_q <= 1'b1;
            spike_addr_q  <= {g_q, lsb_idx(fire_d)};
            state_q       <= EMIT;
          end else if (g_q == G_LAST) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            g_q <= g_q + 1'b1;
          end
        end

        // g is frozen here so the charger is not re-read for this group.
        EMIT: begin
          if (spike_ready_i) begin
            pend_q <= pend_rest_d;
            if (pend_rest_d != 4'd0) begin
              spike_addr_q <= {g_q, lsb_idx(pend_rest_d)};
            end else begin
              spike_valid_q <= 1'b0;
              if (g_q == G_LAST) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                g_q     <= g_q + 1'b1;
                state_q <= SCAN;
              end
            end
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          g_q     <= '0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign charge_count_o = g_q;
  assign spike_valid_o  = spike_valid_q;
  assign spike_addr_o   = spike_addr_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign charge_clear_o = done_q;

endmodule

// File: tb/tb_neuron_integrator.sv
module tb_neuron_integrator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  threshold;
  logic [3:0]  leak;
  logic [5:0]  cc;
  logic [31:0] syn;
  logic        valid;
  logic        ready;
  logic [7:0]  addr;
  logic        busy;
  logic        done;
  logic        clr;

  logic [7:0]  chg [256];

  int checks = 0;
  int errors = 0;

  neuron_integrator #(.N(256)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .threshold_i      (threshold),
    .leak_i           (leak),
    .charge_count_o   (cc),
    .synapse_charge_i (syn),
    .spike_valid_o    (valid),
    .spike_ready_i    (ready),
    .spike_addr_o     (addr),
    .busy_o           (busy),
    .done_o           (done),
    .charge_clear_o   (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural charger: combinational lookup of the addressed group.
  always_comb begin
    syn = {chg[{cc, 2'd3}], chg[{cc, 2'd2}], chg[{cc, 2'd1}], chg[{cc, 2'd0}]};
  end

  typedef struct {
    int addr;
    int wchg; int wthr; int wlk; int wn;
    int pchg; int pthr; int plk;
    int espk; int eaddr; int edone;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    for (int i = 0; i < 256; i++) chg[i] = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One full pass with ready held high. Cycle 1 is the cycle after the start edge.
  task automatic run_pass(input int thr, input int lk,
                          output int nspk, output int first, output int dcyc,
                          output int bcyc, output int ok_order, output int ok_clr);
    int last;
    nspk = 0; first = -1; dcyc = -1; bcyc = 0; ok_order = 1; ok_clr = 1; last = -1;
    @(negedge clk);
    start = 1'b1; threshold = 8'(thr); leak = 4'(lk); ready = 1'b1;
    @(negedge clk);
    start = 1'b0; threshold = ~threshold; leak = ~leak;
    for (int c = 1; c <= 2000; c++) begin
      if (busy) bcyc++;
      if (valid && ready) begin
        if (first < 0) first = int'(addr);
        if (int'(addr) <= last) ok_order = 0;
        last = int'(addr);
        nspk++;
      end
      if (done) begin
        dcyc = c;
        if (!clr) ok_clr = 0;
        break;
      end
      @(negedge clk);
    end
    if (dcyc >= 0) begin
      @(negedge clk);
      if (done || clr || busy) ok_clr = 0;
    end
  endtask

  initial begin
    int nspk, first, dcyc, bcyc, ok_order, ok_clr, seen, ndone;
    vec_t v;

    rst = 1'b1; start = 1'b0; threshold = 8'd0; leak = 4'd0; ready = 1'b0;
    for (int i = 0; i < 256; i++) chg[i] = 8'd0;

    tbl[0]  = '{0,   0,    0,   0,  0, 0,   1,   0,  0,   -1,  65};
    tbl[1]  = '{5,   0,    0,   0,  0, 6,   10,  0,  0,   -1,  65};
    tbl[2]  = '{5,   6,    10,  0,  1, 6,   10,  0,  1,   5,   66};
    tbl[3]  = '{5,   6,    10,  0,  2, 6,   10,  0,  0,   -1,  65};
    tbl[4]  = '{9,   -128, 127, 15, 3, 127, 0,   0,  0,   -1,  65};
    tbl[5]  = '{200, 0,    0,   0,  0, 127, 127, 0,  1,   200, 66};
    tbl[6]  = '{200, 127,  127, 0,  1, 1,   2,   0,  0,   -1,  65};
    tbl[7]  = '{77,  20,   127, 0,  1, 0,   15,  4,  1,   77,  66};
    tbl[8]  = '{0,   0,    0,   0,  0, 0,   -5,  0,  256, 0,   321};
    tbl[9]  = '{0,   0,    0,   0,  0, 0,   -14, 15, 0,   -1,  65};
    tbl[10] = '{130, 100,  127, 0,  1, 100, 127, 0,  1,   130, 66};

    // Reset: two cycles of RST, every output low.
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_addr",  int'(addr),  0);
    chk("rst_cc",    int'(cc),    0);
    chk("rst_busy",  int'(busy),  0);
    chk("rst_done",  int'(done),  0);
    chk("rst_clr",   int'(clr),   0);
    rst = 1'b0;

    // Table: warm-up passes, then a probe pass whose spikes and timing are checked.
    for (int t = 0; t < 11; t++) begin
      v = tbl[t];
      do_reset();
      for (int w = 0; w < v.wn; w++) begin
        chg[v.addr] = 8'(v.wchg);
        run_pass(v.wthr, v.wlk, nspk, first, dcyc, bcyc, ok_order, ok_clr);
      end
      chg[v.addr] = 8'(v.pchg);
      run_pass(v.pthr, v.plk, nspk, first, dcyc, bcyc, ok_order, ok_clr);
      chk($sformatf("v%0d_spikes", t), nspk, v.espk);
      chk($sformatf("v%0d_first", t), first, v.eaddr);
      chk($sformatf("v%0d_done_cyc", t), dcyc, v.edone);
      chk($sformatf("v%0d_busy_cyc", t), bcyc, v.edone);
      chk($sformatf("v%0d_order", t), ok_order, 1);
      chk($sformatf("v%0d_clr_pulse", t), ok_clr, 1);
    end

    // Backpressure on group 3: all four fire, consumer stalls three cycles.
    do_reset();
    for (int i = 12; i < 16; i++) chg[i] = 8'd127;
    @(negedge clk);
    start = 1'b1; threshold = 8'd5; leak = 4'd0;
    @(negedge clk);
    start = 1'b0;
    seen = -1;
    for (int c = 1; c <= 20; c++) begin
      if (valid) begin seen = c; break; end
      @(negedge clk);
    end
    chk("bp_valid_cycle", seen, 5);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_stall%0d_valid", i), int'(valid), 1);
      chk($sformatf("bp_stall%0d_addr", i), int'(addr), 12);
      chk($sformatf("bp_stall%0d_cc", i), int'(cc), 3);
      @(negedge clk);
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_hs%0d_valid", i), int'(valid), 1);
      chk($sformatf("bp_hs%0d_addr", i), int'(addr), 12 + i);
      chk($sformatf("bp_hs%0d_cc", i), int'(cc), 3);
      @(negedge clk);
    end
    chk("bp_after_valid", int'(valid), 0);
    chk("bp_after_cc", int'(cc), 4);
    seen = -1;
    for (int c = 0; c < 200; c++) begin
      if (done) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("bp_done_seen", seen, 1);

    // RST mid-EMIT: pass 1 leaves vmem[40]=8, pass 2 is aborted while stalled.
    do_reset();
    chg[40] = 8'd8;
    for (int i = 12; i < 16; i++) chg[i] = 8'd127;
    run_pass(10, 0, nspk, first, dcyc, bcyc, ok_order, ok_clr);
    chk("ab_p1_spikes", nspk, 4);
    chk("ab_p1_done_cyc", dcyc, 69);
    @(negedge clk);
    start = 1'b1; threshold = 8'd10; leak = 4'd0; ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seen = -1;
    for (int c = 1; c <= 20; c++) begin
      if (valid) begin seen = int'(addr); break; end
      @(negedge clk);
    end
    chk("ab_stall_addr", seen, 12);
    rst = 1'b1;
    @(negedge clk);
    chk("ab_valid_dropped", int'(valid), 0);
    chk("ab_busy_dropped", int'(busy), 0);
    rst = 1'b0;
    ready = 1'b1;
    ndone = 0;
    for (int c = 0; c < 80; c++) begin
      if (done || clr) ndone++;
      @(negedge clk);
    end
    chk("ab_no_done", ndone, 0);
    for (int i = 12; i < 16; i++) chg[i] = 8'd0;
    run_pass(10, 0, nspk, first, dcyc, bcyc, ok_order, ok_clr);
    chk("ab_p3_spikes", nspk, 0);
    chk("ab_p3_done_cyc", dcyc, 65);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
